line_dma_ctrl: RTL and testbench
================================

LINE_DMA_CTRL -- requirements
Module: line_dma_ctrl

Interface
REQ-001 SHALL have parameter WORDS_PER_LINE, default 80, 64-bit words copied per video line (1..512).
REQ-002 SHALL have parameter LINES_PER_FRAME, default 240, lines copied per frame (1..1023).
REQ-003 SHALL have port clk, input, 1, the single clock; reset is synchronous and active-low.
REQ-004 SHALL have port rst_n, input, 1, synchronous active-low reset.
REQ-005 SHALL have port dma_enable, input, 1, level; permits frame copies.
REQ-006 SHALL have port dma_base, input, 32, SDRAM byte address of frame line 0.
REQ-007 SHALL have port vid_vblank, input, 1, vertical blank level.
REQ-008 SHALL have port line_toggle, input, 1, line-buffer select; flips once per completed line.
REQ-009 SHALL have ports lb_address (output, 10), lb_read (output, 1), lb_ack (input, 1) and lb_data (input, 64), forming the line-buffer read port.
REQ-010 SHALL have ports m_address (output, 32), m_write (output, 1), m_writedata (output, 64) and m_waitrequest (input, 1), forming the Avalon-MM write master.
REQ-011 SHALL have ports dma_active (output, 1), frame_counter (output, 32) and frame_done (output, 1, one-cycle pulse).
REQ-012 SHALL have ports overrun (output, 1, sticky) and clear_overrun (input, 1).

Function
REQ-013 SHALL run FSM states IDLE, WAIT_FRAME, WAIT_LINE, READ, WRITE, FRAME_END.
REQ-014 IDLE: dma_enable=1 -> WAIT_FRAME.
REQ-015 WAIT_FRAME: on vid_vblank falling edge, latch dma_base, clear line_idx to 0, and go to WAIT_LINE.
REQ-016 Toggle edge = line_toggle differs from its 1-cycle-delayed copy; the completed buffer is the delayed (old) value.
REQ-017 WAIT_LINE: a toggle edge with line_idx<LINES_PER_FRAME captures buf=old value and cur_line=line_idx, increments line_idx, clears word_idx, and goes to READ.
REQ-018 Toggle edges with line_idx>=LINES_PER_FRAME SHALL be ignored, with no overrun.
REQ-019 READ: lb_read=1 with lb_address={buf, word_idx[8:0]} held stable until lb_ack; on lb_ack, register lb_data and go to WRITE.
REQ-020 WRITE: m_write=1 with m_address=base+((cur_line*WORDS_PER_LINE+word_idx)<<3); address, data and m_write are held until m_waitrequest=0 is sampled.
REQ-021 After an accepted write: if word_idx<WORDS_PER_LINE-1, increment it and go to READ; else go to WAIT_LINE.
REQ-022 The address product SHALL be computed at 32 bits and wrap modulo 2^32.
REQ-023 A toggle edge while in READ or WRITE SHALL set overrun and increment line_idx (that line is not copied, its slot is left unwritten), and SHALL NOT disturb the current copy.
REQ-024 A vid_vblank rising edge in WAIT_LINE -> FRAME_END.
REQ-025 A vid_vblank rising edge in READ/WRITE SHALL be remembered; on the next arrival in WAIT_LINE the FSM goes to FRAME_END.
REQ-026 FRAME_END: one-cycle frame_done=1 and frame_counter+1 (wraps at 2^32); then WAIT_FRAME if dma_enable=1, else IDLE.
REQ-027 A frame with fewer than LINES_PER_FRAME lines still ends normally at vblank.
REQ-028 dma_enable=0 in WAIT_FRAME/WAIT_LINE -> IDLE next cycle with no frame_done.
REQ-029 dma_enable=0 in READ/WRITE: complete the outstanding read and write handshakes, then -> IDLE with no frame_done.
REQ-030 dma_active SHALL be 1 in every state except IDLE.
REQ-031 clear_overrun=1 clears overrun; a simultaneous set wins.
REQ-032 lb_read and m_write SHALL never be asserted together; one word is in flight at most.

Reset
REQ-033 rst_n=0 at a clock edge SHALL force IDLE, overrun=0, frame_counter=0, frame_done=0, lb_read=0, m_write=0, lb_address=0, m_address=0, m_writedata=0, dma_active=0, and load the edge-detect registers from the current inputs.
REQ-034 Reset mid-transaction SHALL abandon the handshake immediately; the memory contents of that line are unspecified.

Structure
REQ-035 Package line_dma_pkg SHALL hold the state enum, BYTES_PER_WORD=8, and the default WORDS_PER_LINE/LINES_PER_FRAME.
REQ-036 Address computation SHALL live in one sub-module, line_dma_addr_gen (combinational base+offset, 32-bit).

Verification (WORDS_PER_LINE=4, LINES_PER_FRAME=3, zero-wait slaves unless stated)
REQ-037 Enable, base 0x1000_0000, vblank falls, then 3 toggles -> 12 writes at 0x1000_0000..0x1000_0058 step 8, data matches buffers; vblank rises -> frame_done pulse, frame_counter=1.
REQ-038 m_waitrequest held 5 cycles on word 2 -> m_address, m_writedata and m_write stable all 5 cycles; exactly 12 writes total.
REQ-039 Second toggle 2 cycles after the first (mid-copy) -> overrun=1, line 1 absent, line 2 written at base+0x40; clear_overrun -> 0.
REQ-040 dma_enable dropped during a WRITE of line 0 word 1 -> that write completes, no further lb_read, dma_active=0, no frame_done.
REQ-041 rst_n=0 for 1 cycle during READ -> all outputs at reset values the next cycle; frame_counter=0.
REQ-042 Fourth toggle after 3 lines -> ignored, no write, overrun stays 0; frame_counter preloaded 0xFFFF_FFFF -> wraps to 0 at frame end.

Source files
------------

// File: rtl/line_dma_pkg.sv
// Shared types and constants for the line-buffer to SDRAM frame copier.
package line_dma_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT_FRAME,
    S_WAIT_LINE,
    S_READ,
    S_WRITE,
    S_FRAME_END
  } state_t;

  localparam int unsigned BYTES_PER_WORD      = 8;
  localparam int unsigned DEF_WORDS_PER_LINE  = 80;
  localparam int unsigned DEF_LINES_PER_FRAME = 240;

endpackage

// File: rtl/line_dma_addr_gen.sv
// SDRAM byte address of one word: base + (line * WORDS_PER_LINE + word) * 8, wrapping at 32 bits.
module line_dma_addr_gen
  import line_dma_pkg::*;
#(
  parameter int unsigned WORDS_PER_LINE = DEF_WORDS_PER_LINE
) (
  input  logic [31:0] base,
  input  logic [9:0]  line,
  input  logic [8:0]  word,
  output logic [31:0] address
);

  localparam logic [31:0] WPL = 32'(WORDS_PER_LINE);
  localparam logic [31:0] BPW = 32'(BYTES_PER_WORD);

  logic [31:0] word_num;

  always_comb begin
    word_num = 32'(line) * WPL + 32'(word);
    address  = base + word_num * BPW;
  end

endmodule

// File: rtl/line_dma_ctrl.sv
// Copies completed video lines from a double line buffer into an SDRAM frame,
// one 64-bit word at a time through an Avalon-MM write master.
module line_dma_ctrl
  import line_dma_pkg::*;
#(
  parameter int unsigned WORDS_PER_LINE  = DEF_WORDS_PER_LINE,
  parameter int unsigned LINES_PER_FRAME = DEF_LINES_PER_FRAME
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        dma_enable,
  input  logic [31:0] dma_base,
  input  logic        vid_vblank,
  input  logic        line_toggle,
  output logic [9:0]  lb_address,
  output logic        lb_read,
  input  logic        lb_ack,
  input  logic [63:0] lb_data,
  output logic [31:0] m_address,
  output logic        m_write,
  output logic [63:0] m_writedata,
  input  logic        m_waitrequest,
  output logic        dma_active,
  output logic [31:0] frame_counter,
  output logic        frame_done,
  output logic        overrun,
  input  logic        clear_overrun
);

  localparam logic [10:0] NUM_LINES = 11'(LINES_PER_FRAME);
  localparam logic [8:0]  LAST_WORD = 9'(WORDS_PER_LINE - 1);

  state_t      state, state_nxt;
  logic        vblank_d, toggle_d;
  logic        vblank_fall, vblank_rise, tog_edge, line_ok, busy;
  logic        frame_start, take_line, skip_line, wr_done;
  logic        vblank_pend, stop_pend, buf_sel;
  logic [31:0] base_q, addr_next;
  logic [10:0] line_idx;
  logic [9:0]  cur_line;
  logic [8:0]  word_idx;

  line_dma_addr_gen #(.WORDS_PER_LINE(WORDS_PER_LINE)) u_addr_gen (
    .base    (base_q),
    .line    (cur_line),
    .word    (word_idx),
    .address (addr_next)
  );

  assign vblank_fall = vblank_d & ~vid_vblank;
  assign vblank_rise = ~vblank_d & vid_vblank;
  assign tog_edge    = line_toggle ^ toggle_d;
  assign line_ok     = line_idx < NUM_LINES;
  assign busy        = (state == S_READ) || (state == S_WRITE);
  assign skip_line   = busy && tog_edge && line_ok;
  assign wr_done     = (state == S_WRITE) && !m_waitrequest;

  assign lb_read    = (state == S_READ);
  assign lb_address = lb_read ? {buf_sel, word_idx} : '0;
  assign m_write    = (state == S_WRITE);
  assign dma_active = (state != S_IDLE);
  assign frame_done = (state == S_FRAME_END);

  always_comb begin
    state_nxt   = state;
    frame_start = 1'b0;
    take_line   = 1'b0;
    case (state)
      S_IDLE:
        if (dma_enable) state_nxt = S_WAIT_FRAME;
      S_WAIT_FRAME:
        if (!dma_enable) state_nxt = S_IDLE;
        else if (vblank_fall) begin
          frame_start = 1'b1;
          state_nxt   = S_WAIT_LINE;
        end
      S_WAIT_LINE:
        if (!dma_enable) state_nxt = S_IDLE;
        else if (vblank_rise || vblank_pend) state_nxt = S_FRAME_END;
        else if (tog_edge && line_ok) begin
          take_line = 1'b1;
          state_nxt = S_READ;
        end
      S_READ:
        if (lb_ack) state_nxt = S_WRITE;
      S_WRITE:
        if (!m_waitrequest) begin
          if (stop_pend || !dma_enable) state_nxt = S_IDLE;
          else if (word_idx < LAST_WORD) state_nxt = S_READ;
          else state_nxt = S_WAIT_LINE;
        end
      S_FRAME_END:
        state_nxt = dma_enable ? S_WAIT_FRAME : S_IDLE;
      default:
        state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // Edge detectors track the inputs through reset so no false edge follows it.
  always_ff @(posedge clk) begin
    vblank_d <= vid_vblank;
    toggle_d <= line_toggle;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      base_q        <= '0;
      line_idx      <= '0;
      cur_line      <= '0;
      buf_sel       <= 1'b0;
      word_idx      <= '0;
      m_address     <= '0;
      m_writedata   <= '0;
      frame_counter <= '0;
      overrun       <= 1'b0;
      vblank_pend   <= 1'b0;
      stop_pend     <= 1'b0;
    end else begin
      if (frame_start) begin
        base_q   <= dma_base;
        line_idx <= '0;
      end else if (take_line || skip_line) begin
        line_idx <= line_idx + 11'd1;
      end
      if (take_line) begin
        cur_line <= line_idx[9:0];
        buf_sel  <= toggle_d;
        word_idx <= '0;
      end else if (wr_done && word_idx < LAST_WORD) begin
        word_idx <= word_idx + 9'd1;
      end
      if (lb_read && lb_ack) begin
        m_writedata <= lb_data;
        m_address   <= addr_next;
      end
      if (skip_line)          overrun <= 1'b1;
      else if (clear_overrun) overrun <= 1'b0;
      // Vblank and disable seen mid-word are deferred until the word is written.
      vblank_pend <= busy && (vblank_pend || vblank_rise);
      stop_pend   <= busy && (stop_pend || !dma_enable);
      if (state == S_FRAME_END) frame_counter <= frame_counter + 32'd1;
    end
  end

endmodule

// File: tb/tb_line_dma_ctrl.sv
// Directed checks of line_dma_ctrl with 4 words/line, 3 lines/frame.
module tb_line_dma_ctrl;

  localparam int unsigned WPL  = 4;
  localparam int unsigned LPF  = 3;
  localparam logic [31:0] BASE = 32'h1000_0000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        dma_enable = 1'b0;
  logic [31:0] dma_base = BASE;
  logic        vid_vblank = 1'b1;
  logic        line_toggle = 1'b0;
  logic        clear_overrun = 1'b0;
  logic [9:0]  lb_address;
  logic        lb_read, lb_ack;
  logic [63:0] lb_data;
  logic [31:0] m_address;
  logic        m_write, m_waitrequest;
  logic [63:0] m_writedata;
  logic        dma_active, frame_done, overrun;
  logic [31:0] frame_counter;

  always #5 clk = ~clk;

  line_dma_ctrl #(.WORDS_PER_LINE(WPL), .LINES_PER_FRAME(LPF)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .dma_enable    (dma_enable),
    .dma_base      (dma_base),
    .vid_vblank    (vid_vblank),
    .line_toggle   (line_toggle),
    .lb_address    (lb_address),
    .lb_read       (lb_read),
    .lb_ack        (lb_ack),
    .lb_data       (lb_data),
    .m_address     (m_address),
    .m_write       (m_write),
    .m_writedata   (m_writedata),
    .m_waitrequest (m_waitrequest),
    .dma_active    (dma_active),
    .frame_counter (frame_counter),
    .frame_done    (frame_done),
    .overrun       (overrun),
    .clear_overrun (clear_overrun)
  );

  // Slave models: line buffer answers at once unless held; SDRAM stalls 5 cycles on stall_addr.
  logic        lb_hold = 1'b0;
  logic [31:0] stall_addr = '1;
  int unsigned stall_cnt = 0;

  assign lb_ack        = lb_read && !lb_hold;
  assign lb_data       = {22'h0AB0CD, lb_address, 22'h3C5A5A, ~lb_address};
  assign m_waitrequest = m_write && (m_address == stall_addr) && (stall_cnt < 5);

  always @(posedge clk) stall_cnt <= m_waitrequest ? stall_cnt + 1 : 0;

  logic [31:0] wr_addr[$];
  logic [63:0] wr_data[$];
  int unsigned rd_cnt = 0, done_cnt = 0, overlap_cnt = 0;

  always @(negedge clk) begin
    if (m_write && !m_waitrequest) begin
      wr_addr.push_back(m_address);
      wr_data.push_back(m_writedata);
    end
    if (lb_read && lb_ack)  rd_cnt      <= rd_cnt + 1;
    if (frame_done)         done_cnt    <= done_cnt + 1;
    if (lb_read && m_write) overlap_cnt <= overlap_cnt + 1;
  end

  int unsigned vec_cnt = 0, err_cnt = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] data_of(input logic b, input logic [8:0] w);
    return {22'h0AB0CD, b, w, 22'h3C5A5A, ~{b, w}};
  endfunction

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic toggle(output logic old);
    old = line_toggle;
    line_toggle = ~line_toggle;
  endtask

  task automatic clear_log();
    wr_addr.delete();
    wr_data.delete();
  endtask

  task automatic wait_stall(input string tag);
    logic ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (m_waitrequest) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    check(tag, 64'(ok), 64'd1);
  endtask

  task automatic start_frame();
    vid_vblank = 1'b1;
    cycles(2);
    vid_vblank = 1'b0;
    cycles(3);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish, got running, expected finished");
    $fatal(1);
  end

  initial begin
    logic        bufs[3];
    logic        b;
    logic        ok;
    int unsigned rdc, dc;

    cycles(3);
    rst_n = 1'b1;
    cycles(1);
    check("rst_active",  64'(dma_active), 64'd0);
    check("rst_lb_read", 64'(lb_read), 64'd0);
    check("rst_m_write", 64'(m_write), 64'd0);
    check("rst_m_addr",  64'(m_address), 64'd0);
    check("rst_m_data",  m_writedata, 64'd0);
    check("rst_fcnt",    64'(frame_counter), 64'd0);
    check("rst_overrun", 64'(overrun), 64'd0);
    check("rst_done",    64'(frame_done), 64'd0);

    // Full frame of three lines.
    dma_enable = 1'b1;
    cycles(2);
    check("en_active", 64'(dma_active), 64'd1);
    vid_vblank = 1'b0;
    cycles(3);
    clear_log();
    for (int l = 0; l < 3; l++) begin
      toggle(bufs[l]);
      cycles(12);
    end
    check("f1_nwr", 64'(wr_addr.size()), 64'd12);
    for (int i = 0; i < 12 && i < wr_addr.size(); i++) begin
      check("f1_addr", 64'(wr_addr[i]), 64'(BASE + 32'(8 * i)));
      check("f1_data", wr_data[i], data_of(bufs[i / 4], 9'(i % 4)));
    end
    vid_vblank = 1'b1;
    cycles(4);
    check("f1_done", 64'(done_cnt), 64'd1);
    check("f1_fcnt", 64'(frame_counter), 64'd1);

    // Slave stall on line 0 word 2.
    vid_vblank = 1'b0;
    cycles(3);
    clear_log();
    stall_addr = BASE + 32'h10;
    toggle(bufs[0]);
    wait_stall("stall_seen");
    for (int k = 0; k < 5; k++) begin
      check("stall_write", 64'(m_write), 64'd1);
      check("stall_addr",  64'(m_address), 64'(BASE + 32'h10));
      check("stall_data",  m_writedata, data_of(bufs[0], 9'd2));
      @(negedge clk);
    end
    cycles(12);
    toggle(bufs[1]);
    cycles(12);
    toggle(bufs[2]);
    cycles(12);
    stall_addr = '1;
    check("stall_nwr", 64'(wr_addr.size()), 64'd12);
    if (wr_addr.size() == 12) begin
      check("stall_last_addr", 64'(wr_addr[11]), 64'(BASE + 32'h58));
      check("stall_last_data", wr_data[11], data_of(bufs[2], 9'd3));
    end
    vid_vblank = 1'b1;
    cycles(4);
    check("f2_fcnt", 64'(frame_counter), 64'd2);

    // Second toggle arrives mid-copy: line 1 dropped, overrun flagged.
    vid_vblank = 1'b0;
    cycles(3);
    clear_log();
    check("ovr_pre", 64'(overrun), 64'd0);
    toggle(bufs[0]);
    cycles(2);
    toggle(bufs[1]);
    cycles(12);
    toggle(bufs[2]);
    cycles(12);
    check("ovr_set", 64'(overrun), 64'd1);
    check("ovr_nwr", 64'(wr_addr.size()), 64'd8);
    if (wr_addr.size() == 8) begin
      check("ovr_l0_end",  64'(wr_addr[3]), 64'(BASE + 32'h18));
      check("ovr_l2_addr", 64'(wr_addr[4]), 64'(BASE + 32'h40));
      check("ovr_l2_data", wr_data[4], data_of(bufs[2], 9'd0));
      check("ovr_l2_end",  64'(wr_addr[7]), 64'(BASE + 32'h58));
    end
    clear_overrun = 1'b1;
    cycles(1);
    clear_overrun = 1'b0;
    check("ovr_clr", 64'(overrun), 64'd0);
    vid_vblank = 1'b1;
    cycles(4);
    check("f3_fcnt", 64'(frame_counter), 64'd3);

    // Disable while line 0 word 1 is being written.
    vid_vblank = 1'b0;
    cycles(3);
    clear_log();
    stall_addr = BASE + 32'h8;
    toggle(bufs[0]);
    wait_stall("dis_seen");
    dma_enable = 1'b0;
    rdc = rd_cnt;
    dc  = done_cnt;
    cycles(12);
    stall_addr = '1;
    check("dis_nwr", 64'(wr_addr.size()), 64'd2);
    if (wr_addr.size() == 2) begin
      check("dis_addr", 64'(wr_addr[1]), 64'(BASE + 32'h8));
      check("dis_data", wr_data[1], data_of(bufs[0], 9'd1));
    end
    check("dis_reads",  64'(rd_cnt), 64'(rdc));
    check("dis_active", 64'(dma_active), 64'd0);
    check("dis_done",   64'(done_cnt), 64'(dc));
    check("dis_fcnt",   64'(frame_counter), 64'd3);

    // Reset while a read is pending.
    dma_enable = 1'b1;
    cycles(1);
    start_frame();
    lb_hold = 1'b1;
    toggle(b);
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (lb_read) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    check("rd_seen", 64'(ok), 64'd1);
    rst_n = 1'b0;
    cycles(1);
    rst_n   = 1'b1;
    lb_hold = 1'b0;
    check("mid_rst_lb_read", 64'(lb_read), 64'd0);
    check("mid_rst_lb_addr", 64'(lb_address), 64'd0);
    check("mid_rst_m_write", 64'(m_write), 64'd0);
    check("mid_rst_m_addr",  64'(m_address), 64'd0);
    check("mid_rst_m_data",  m_writedata, 64'd0);
    check("mid_rst_active",  64'(dma_active), 64'd0);
    check("mid_rst_fcnt",    64'(frame_counter), 64'd0);
    check("mid_rst_done",    64'(frame_done), 64'd0);

    // Fourth toggle past the last line is ignored; frame counter wraps.
    cycles(1);
    start_frame();
    clear_log();
    for (int l = 0; l < 3; l++) begin
      toggle(bufs[l]);
      cycles(12);
    end
    toggle(b);
    cycles(12);
    check("extra_nwr",     64'(wr_addr.size()), 64'd12);
    check("extra_overrun", 64'(overrun), 64'd0);
    if (wr_addr.size() == 12)
      check("extra_last", 64'(wr_addr[11]), 64'(BASE + 32'h58));
    force dut.frame_counter = 32'hFFFF_FFFF;
    cycles(1);
    release dut.frame_counter;
    cycles(1);
    check("wrap_pre", 64'(frame_counter), 64'hFFFF_FFFF);
    dc = done_cnt;
    vid_vblank = 1'b1;
    cycles(4);
    check("wrap_fcnt", 64'(frame_counter), 64'd0);
    check("wrap_done", 64'(done_cnt), 64'(dc + 1));

    check("no_overlap", 64'(overlap_cnt), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
